fu_rr_sequencer: RTL and testbench

//  Shares one combinational Functional_Unit between two requesters.
//  - Round-robin arbitration between the two request ports.
//  - Registers the winner's instruction and operands, then drives them onto the FU for EXEC_CYCLES.
//  - Captures F and returns it with requester id on a valid/ready response port.
//  - Sits between issue logic and the FU; the FU itself is instantiated outside this block.

---
 rtl/fu_rr_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_fu_rr_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_rr_sequencer.sv
// -----------------------------------------------------------------------------
// FuRrSequencer (top module fu_rr_sequencer)
//
// Purpose:
//   Lets two requesters share one external combinational functional unit.
//   A round-robin arbiter picks one request while idle. The sequencer then
//   registers that request's instruction and operands and holds them on the
//   FU inputs for EXEC_CYCLES cycles. On the last of those cycles it captures
//   the FU result and offers it, tagged with the requester id, on a
//   valid/ready response port.
//
// Parameters:
//   WIDTH        operand / result width (instruction is always 8 bits)
//   EXEC_CYCLES  cycles the FU inputs are held before F is sampled (1..15)
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   req0_valid_i        requester 0 has an operation pending
//   req0_ready_o        requester 0 accepted this cycle
//   req0_instr_i        requester 0 instruction word (8 bits)
//   req0_a/b/c_i        requester 0 operands
//   req1_*              same set for requester 1
//   fu_instruction_o    instruction driven to the FU (zero unless executing)
//   fu_a/b/c_o          operands driven to the FU (zero unless executing)
//   fu_f_i              FU result
//   resp_valid_o        result available
//   resp_ready_i        consumer takes the result
//   resp_data_o         captured F (zero for an error response)
//   resp_id_o           requester that issued the operation
//   resp_err_o          the instruction was all zeros
//   busy_o              sequencer is not idle
// -----------------------------------------------------------------------------
module fu_rr_sequencer #(
  parameter int WIDTH       = 8,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [7:0]       req0_instr_i,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [WIDTH-1:0] req0_c_i,

  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [7:0]       req1_instr_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic [WIDTH-1:0] req1_c_i,

  output logic [7:0]       fu_instruction_o,
  output logic [WIDTH-1:0] fu_a_o,
  output logic [WIDTH-1:0] fu_b_o,
  output logic [WIDTH-1:0] fu_c_o,
  input  logic [WIDTH-1:0] fu_f_i,

  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] resp_data_o,
  output logic             resp_id_o,
  output logic             resp_err_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Countdown start value: the counter reaches zero on the last execute cycle.
  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_e           state_q,     state_d;
  logic [3:0]       cnt_q,       cnt_d;
  logic             lastGrant_q, lastGrant_d;
  logic [7:0]       instr_q,     instr_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic [WIDTH-1:0] c_q,         c_d;
  logic             id_q,        id_d;
  logic [WIDTH-1:0] data_q,      data_d;
  logic             err_q,       err_d;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             acceptId;
  logic [7:0]       selInstr;
  logic [WIDTH-1:0] selA;
  logic [WIDTH-1:0] selB;
  logic [WIDTH-1:0] selC;

  // Round-robin arbitration. A lone valid request always wins. When both are
  // valid, the requester that did not win last time gets the grant. Ready is
  // only offered while idle, so at most one ready is ever high.
  always_comb begin
    grant0       = req0_valid_i & (~req1_valid_i | lastGrant_q);
    grant1       = req1_valid_i & (~req0_valid_i | ~lastGrant_q);
    req0_ready_o = (state_q == IDLE) & grant0;
    req1_ready_o = (state_q == IDLE) & grant1;
    accept       = req0_ready_o | req1_ready_o;
    acceptId     = req1_ready_o;
    selInstr     = acceptId ? req1_instr_i : req0_instr_i;
    selA         = acceptId ? req1_a_i     : req0_a_i;
    selB         = acceptId ? req1_b_i     : req0_b_i;
    selC         = acceptId ? req1_c_i     : req0_c_i;
  end

  // Next-state logic and datapath capture. An all-zero instruction matches no
  // FU operation, so it skips execution and goes straight to an error response.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lastGrant_d = lastGrant_q;
    instr_d     = instr_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    id_d        = id_q;
    data_d      = data_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          lastGrant_d = acceptId;
          id_d        = acceptId;
          instr_d     = selInstr;
          a_d         = selA;
          b_d         = selB;
          c_d         = selC;
          if (selInstr == 8'h00) begin
            state_d = RESP;
            err_d   = 1'b1;
            data_d  = '0;
          end else begin
            state_d = EXEC;
            err_d   = 1'b0;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          data_d  = fu_f_i;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. The last grant resets to requester 1 so that
  // requester 0 wins the first contested arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      lastGrant_q <= 1'b1;
      instr_q     <= 8'h00;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      id_q        <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lastGrant_q <= lastGrant_d;
      instr_q     <= instr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      id_q        <= id_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  // Output decode from registered state only. The FU sees the captured
  // operation only while executing, so there is no path from the request
  // ports to the FU. Response fields are gated to zero outside RESP.
  always_comb begin
    fu_instruction_o = 8'h00;
    fu_a_o           = '0;
    fu_b_o           = '0;
    fu_c_o           = '0;
    if (state_q == EXEC) begin
      fu_instruction_o = instr_q;
      fu_a_o           = a_q;
      fu_b_o           = b_q;
      fu_c_o           = c_q;
    end
    resp_valid_o = (state_q == RESP);
    resp_data_o  = (state_q == RESP) ? data_q : '0;
    resp_id_o    = (state_q == RESP) & id_q;
    resp_err_o   = (state_q == RESP) & err_q;
    busy_o       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_fu_rr_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for fu_rr_sequencer.
//
// The bench has two instances. The first uses EXEC_CYCLES=1. The second uses
// EXEC_CYCLES=4 and exercises the long-execute and mid-operation reset cases.
// A behavioural functional-unit model drives fu_f for each instance from that
// instance's fu_* outputs. The model chooses the lowest set instruction bit.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fu_rr_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // Instance with EXEC_CYCLES = 1
  logic       r0Valid, r0Ready, r1Valid, r1Ready;
  logic [7:0] r0Instr, r0A, r0B, r0C, r1Instr, r1A, r1B, r1C;
  logic [7:0] fuInstr, fuA, fuB, fuC, fuF;
  logic       respValid, respReady, respId, respErr, busy;
  logic [7:0] respData;

  // Instance with EXEC_CYCLES = 4
  logic       xr0Valid, xr0Ready, xr1Valid, xr1Ready;
  logic [7:0] xr0Instr, xr0A, xr0B, xr0C, xr1Instr, xr1A, xr1B, xr1C;
  logic [7:0] xFuInstr, xFuA, xFuB, xFuC, xFuF;
  logic       xRespValid, xRespReady, xRespId, xRespErr, xBusy;
  logic [7:0] xRespData;

  int assertCount = 0;
  int failCount   = 0;

  // External functional unit: the lowest set instruction bit picks the op.
  function automatic logic [7:0] fuModel(input logic [7:0] instr, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c);
    if (instr[0]) return a + c;
    if (instr[1]) return a - c;
    if (instr[2]) return a & c;
    if (instr[3]) return b | c;
    if (instr[4]) return a ^ b;
    if (instr[5]) return ~a;
    if (instr[6]) return b + c;
    if (instr[7]) return a | b | c;
    return 8'h00;
  endfunction

  assign fuF  = fuModel(fuInstr, fuA, fuB, fuC);
  assign xFuF = fuModel(xFuInstr, xFuA, xFuB, xFuC);

  fu_rr_sequencer #(.WIDTH(8), .EXEC_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(r0Valid), .req0_ready_o(r0Ready), .req0_instr_i(r0Instr),
    .req0_a_i(r0A), .req0_b_i(r0B), .req0_c_i(r0C),
    .req1_valid_i(r1Valid), .req1_ready_o(r1Ready), .req1_instr_i(r1Instr),
    .req1_a_i(r1A), .req1_b_i(r1B), .req1_c_i(r1C),
    .fu_instruction_o(fuInstr), .fu_a_o(fuA), .fu_b_o(fuB), .fu_c_o(fuC), .fu_f_i(fuF),
    .resp_valid_o(respValid), .resp_ready_i(respReady), .resp_data_o(respData),
    .resp_id_o(respId), .resp_err_o(respErr), .busy_o(busy)
  );

  fu_rr_sequencer #(.WIDTH(8), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(xr0Valid), .req0_ready_o(xr0Ready), .req0_instr_i(xr0Instr),
    .req0_a_i(xr0A), .req0_b_i(xr0B), .req0_c_i(xr0C),
    .req1_valid_i(xr1Valid), .req1_ready_o(xr1Ready), .req1_instr_i(xr1Instr),
    .req1_a_i(xr1A), .req1_b_i(xr1B), .req1_c_i(xr1C),
    .fu_instruction_o(xFuInstr), .fu_a_o(xFuA), .fu_b_o(xFuB), .fu_c_o(xFuC), .fu_f_i(xFuF),
    .resp_valid_o(xRespValid), .resp_ready_i(xRespReady), .resp_data_o(xRespData),
    .resp_id_o(xRespId), .resp_err_o(xRespErr), .busy_o(xBusy)
  );

  typedef struct {
    logic       id;
    logic [7:0] instr;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] expData;
    logic       expErr;
  } vec_t;

  vec_t vecs[10];

  // Compare one observed value against the expected value and count the result.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Hold reset for two cycles and release it on a falling edge.
  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Run one complete transaction on the EXEC_CYCLES=1 instance and check the
  // grant, the FU drive, the response latency and the response contents.
  task automatic applyStimulus(input logic id, input logic [7:0] instr, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] c,
                               input logic [7:0] expData, input logic expErr, input string tag);
    int lat;
    @(negedge clk);
    if (id == 1'b0) begin
      r0Valid = 1'b1; r0Instr = instr; r0A = a; r0B = b; r0C = c;
    end else begin
      r1Valid = 1'b1; r1Instr = instr; r1A = a; r1B = b; r1C = c;
    end
    #1;
    checkOutput($sformatf("%s ready", tag), {r1Ready, r0Ready}, id ? 2'b10 : 2'b01);
    @(negedge clk);
    r0Valid = 1'b0;
    r1Valid = 1'b0;
    lat = 1;
    checkOutput($sformatf("%s fu_instruction", tag), fuInstr, expErr ? 8'h00 : instr);
    while (!respValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput($sformatf("%s latency", tag), lat, expErr ? 1 : 2);
    checkOutput($sformatf("%s resp_data", tag), respData, expData);
    checkOutput($sformatf("%s resp_id", tag), respId, id);
    checkOutput($sformatf("%s resp_err", tag), respErr, expErr);
    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
    checkOutput($sformatf("%s valid drop", tag), {respValid, busy}, 2'b00);
  endtask

  initial begin
    logic       expId;
    int         n0, n1, lat;
    logic       seenValid;
    // Random-phase reference model: transaction-level view of the sequencer
    logic       lastG, haveResp, g, anyReq, accepted0, accepted1;
    int         respAt;
    logic [7:0] expData, holdInstr;
    logic       expErr, expRespId, expValid;

    vecs[0] = '{1'b0, 8'h01, 8'h03, 8'h00, 8'h04, 8'h07, 1'b0};
    vecs[1] = '{1'b1, 8'h08, 8'h00, 8'hF0, 8'h0F, 8'hFF, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 8'h12, 8'h34, 8'h56, 8'h00, 1'b1};
    vecs[3] = '{1'b0, 8'h04, 8'hAA, 8'h00, 8'h0F, 8'h0A, 1'b0};
    vecs[4] = '{1'b0, 8'h02, 8'h10, 8'h00, 8'h03, 8'h0D, 1'b0};
    vecs[5] = '{1'b1, 8'h10, 8'h5A, 8'hFF, 8'h00, 8'hA5, 1'b0};
    vecs[6] = '{1'b0, 8'h06, 8'h20, 8'h00, 8'h01, 8'h1F, 1'b0};
    vecs[7] = '{1'b1, 8'h80, 8'h01, 8'h02, 8'h04, 8'h07, 1'b0};
    vecs[8] = '{1'b0, 8'h20, 8'h0F, 8'h00, 8'h00, 8'hF0, 1'b0};
    vecs[9] = '{1'b1, 8'h40, 8'h00, 8'hFE, 8'h03, 8'h01, 1'b0};

    {r0Valid, r1Valid, respReady} = '0;
    {r0Instr, r0A, r0B, r0C, r1Instr, r1A, r1B, r1C} = '0;
    {xr0Valid, xr1Valid, xRespReady} = '0;
    {xr0Instr, xr0A, xr0B, xr0C} = '0;
    xr1Instr = 8'h01; xr1A = 8'h01; xr1B = 8'h00; xr1C = 8'h01;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset outputs", {respValid, busy, fuInstr, respData, r0Ready, r1Ready},
                '0);
    checkOutput("reset outputs x4", {xRespValid, xBusy, xFuInstr, xRespData}, '0);
    rst_n = 1'b1;

    // Both requesters contend with three operations each: strict alternation from req0
    @(negedge clk);
    n0 = 0; n1 = 0;
    r0Valid = 1'b1; r0Instr = 8'h01; r0A = 8'h10; r0B = 8'h00; r0C = 8'h01;
    r1Valid = 1'b1; r1Instr = 8'h08; r1A = 8'h00; r1B = 8'hF0; r1C = 8'h0F;
    for (int k = 0; k < 6; k++) begin
      expId = k[0];
      #1;
      checkOutput($sformatf("rr grant %0d", k), {r1Ready, r0Ready}, expId ? 2'b10 : 2'b01);
      @(negedge clk);
      if (expId == 1'b0) begin
        n0++;
        if (n0 == 3) r0Valid = 1'b0; else r0A = 8'h10 + 8'(n0);
      end else begin
        n1++;
        if (n1 == 3) r1Valid = 1'b0;
      end
      #1;
      checkOutput($sformatf("rr ready in exec %0d", k), {r1Ready, r0Ready}, 2'b00);
      lat = 1;
      while (!respValid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      checkOutput($sformatf("rr latency %0d", k), lat, 2);
      checkOutput($sformatf("rr resp %0d", k), {respId, respErr, respData},
                  {expId, 1'b0, expId ? 8'hFF : 8'h11 + 8'(k / 2)});
      respReady = 1'b1;
      @(negedge clk);
      respReady = 1'b0;
    end

    // Table of single transactions
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].id, vecs[i].instr, vecs[i].a, vecs[i].b, vecs[i].c,
                    vecs[i].expData, vecs[i].expErr, $sformatf("vec %0d", i));
    end

    // Response back-pressure: everything holds while resp_ready stays low
    @(negedge clk);
    r0Valid = 1'b1; r0Instr = 8'h02; r0A = 8'h09; r0B = 8'h00; r0C = 8'h02;
    @(negedge clk);
    r0Valid = 1'b0;
    r1Valid = 1'b1; r1Instr = 8'h10; r1A = 8'h33; r1B = 8'h0F; r1C = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("hold cycle %0d", i),
                  {respValid, respData, respId, respErr, r1Ready, r0Ready, busy},
                  {1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      @(negedge clk);
    end
    respReady = 1'b1;
    #1;
    checkOutput("no accept in handshake cycle", {r1Ready, r0Ready}, 2'b00);
    @(negedge clk);
    respReady = 1'b0;
    #1;
    checkOutput("accept after release", {respValid, r1Ready, r0Ready}, 3'b010);
    @(negedge clk);
    r1Valid = 1'b0;
    lat = 1;
    while (!respValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("post-hold resp", {respId, respErr, respData}, {1'b1, 1'b0, 8'h3C});
    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;

    // EXEC_CYCLES=4: FU inputs held for four cycles, response on the fifth
    @(negedge clk);
    xr0Valid = 1'b1; xr0Instr = 8'h04; xr0A = 8'hAA; xr0B = 8'h00; xr0C = 8'h0F;
    #1;
    checkOutput("x4 ready", xr0Ready, 1'b1);
    @(negedge clk);
    xr0Valid = 1'b0; xr0Instr = 8'h55; xr0A = 8'h55; xr0C = 8'h55;
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("x4 exec cycle %0d", i), {xFuInstr, xFuA, xFuC, xRespValid},
                  {8'h04, 8'hAA, 8'h0F, 1'b0});
      @(negedge clk);
    end
    checkOutput("x4 resp at cycle 5", {xRespValid, xRespId, xRespErr, xRespData},
                {1'b1, 1'b0, 1'b0, 8'h0A});
    xRespReady = 1'b1;
    @(negedge clk);
    xRespReady = 1'b0;

    // Reset pulsed in the middle of execution discards the operation
    xr0Valid = 1'b1; xr0Instr = 8'h01; xr0A = 8'h01; xr0C = 8'h01;
    @(negedge clk);
    xr0Valid = 1'b0;
    @(negedge clk);
    checkOutput("x4 busy before reset", {xBusy, xFuInstr}, {1'b1, 8'h01});
    #2 rst_n = 1'b0;
    #1;
    checkOutput("x4 async reset outputs", {xFuInstr, xFuA, xFuC, xBusy, xRespValid, xRespData},
                '0);
    @(negedge clk);
    rst_n = 1'b1;
    seenValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seenValid = seenValid | xRespValid | xBusy;
    end
    checkOutput("x4 no resp after reset", seenValid, 1'b0);
    xr0Valid = 1'b1; xr1Valid = 1'b1;
    #1;
    checkOutput("x4 first grant after reset", {xr1Ready, xr0Ready}, 2'b01);
    @(negedge clk);
    xr0Valid = 1'b0; xr1Valid = 1'b0;

    // Randomised traffic against a transaction-level model
    doReset();
    lastG = 1'b1; haveResp = 1'b0; respAt = 0;
    expData = 8'h00; expErr = 1'b0; expRespId = 1'b0; holdInstr = 8'h00;
    for (int t = 0; t < 600; t++) begin
      if (!r0Valid && $urandom_range(0, 2) != 0) begin
        r0Valid = 1'b1;
        r0Instr = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        r0A = 8'($urandom); r0B = 8'($urandom); r0C = 8'($urandom);
      end
      if (!r1Valid && $urandom_range(0, 2) != 0) begin
        r1Valid = 1'b1;
        r1Instr = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        r1A = 8'($urandom); r1B = 8'($urandom); r1C = 8'($urandom);
      end
      respReady = ($urandom_range(0, 3) != 0);
      #1;
      anyReq = r0Valid | r1Valid;
      g = (r0Valid && r1Valid) ? ~lastG : r1Valid;
      accepted0 = 1'b0;
      accepted1 = 1'b0;
      checkOutput("rand ready", {r1Ready, r0Ready},
                  (!haveResp && anyReq) ? (g ? 2'b10 : 2'b01) : 2'b00);
      checkOutput("rand busy", busy, haveResp);
      expValid = haveResp && (t >= respAt);
      checkOutput("rand resp_valid", respValid, expValid);
      checkOutput("rand fu_instruction", fuInstr,
                  (haveResp && t < respAt) ? holdInstr : 8'h00);
      if (expValid) begin
        checkOutput("rand resp", {respId, respErr, respData}, {expRespId, expErr, expData});
        if (respReady) haveResp = 1'b0;
      end else if (!haveResp && anyReq) begin
        haveResp  = 1'b1;
        holdInstr = g ? r1Instr : r0Instr;
        expErr    = (holdInstr == 8'h00);
        expData   = g ? fuModel(r1Instr, r1A, r1B, r1C) : fuModel(r0Instr, r0A, r0B, r0C);
        expRespId = g;
        respAt    = t + (expErr ? 1 : 2);
        lastG     = g;
        accepted0 = ~g;
        accepted1 = g;
      end
      @(negedge clk);
      if (accepted0) r0Valid = 1'b0;
      if (accepted1) r1Valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
